// File: rtl/vdip_pkg.sv
// rtl/vdip_pkg.sv - shared widths, defaults and counter sizing for the DIP conditioner
package vdip_pkg;

  localparam int VDIP_W           = 16;
  localparam int DEBOUNCE_DEFAULT = 1024;

  // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/vdip_debounce_bit.sv
// rtl/vdip_debounce_bit.sv - one DIP bit: 2-flop synchronizer, stability counter, accepted level, edge pulses
module vdip_debounce_bit
  import vdip_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] count;

  // Acceptance is decided combinationally so the top can register its OR in step with the pulse flops.
  assign accept = (sync2 != level) && (count == CNT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      count <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level || accept) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
      if (accept) begin
        level <= sync2;
      end
      rise <= accept & sync2;
      fall <= accept & ~sync2;
    end
  end

endmodule

// File: rtl/vdip_conditioner.sv
// rtl/vdip_conditioner.sv - per-bit debounce of the shell DIP switches into the core's vdip input
module vdip_conditioner
  import vdip_pkg::*;
#(
  parameter int WIDTH           = VDIP_W,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dip_raw,
  output logic [WIDTH-1:0] vdip,
  output logic [WIDTH-1:0] vdip_rise,
  output logic [WIDTH-1:0] vdip_fall,
  output logic             vdip_changed
);

  logic [WIDTH-1:0] accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    vdip_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .raw    (dip_raw[i]),
      .level  (vdip[i]),
      .rise   (vdip_rise[i]),
      .fall   (vdip_fall[i]),
      .accept (accept[i])
    );
  end

  // Registering the OR of the accept strobes lines vdip_changed up with the pulse flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vdip_changed <= 1'b0;
    end else begin
      vdip_changed <= |accept;
    end
  end

endmodule
